// File: rtl/axis_frame_inject.sv
// AXI4-Stream frame injector: merges whole frames from an inject stream into a
// main stream at frame boundaries, behind a registered two-entry skid output stage.
module axis_frame_inject #(
  parameter int DATA_WIDTH      = 8,
  parameter int KEEP_ENABLE     = (DATA_WIDTH > 8),
  parameter int KEEP_WIDTH      = ((DATA_WIDTH + 7) / 8),
  parameter int USER_ENABLE     = 1,
  parameter int USER_WIDTH      = 1,
  parameter int INJECT_PRIORITY = 0,
  parameter int COUNT_WIDTH     = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [DATA_WIDTH-1:0]  s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0]  s_axis_tkeep,
  input  logic                   s_axis_tvalid,
  output logic                   s_axis_tready,
  input  logic                   s_axis_tlast,
  input  logic [USER_WIDTH-1:0]  s_axis_tuser,
  input  logic [DATA_WIDTH-1:0]  inj_axis_tdata,
  input  logic [KEEP_WIDTH-1:0]  inj_axis_tkeep,
  input  logic                   inj_axis_tvalid,
  output logic                   inj_axis_tready,
  input  logic                   inj_axis_tlast,
  input  logic [USER_WIDTH-1:0]  inj_axis_tuser,
  output logic [DATA_WIDTH-1:0]  m_axis_tdata,
  output logic [KEEP_WIDTH-1:0]  m_axis_tkeep,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready,
  output logic                   m_axis_tlast,
  output logic [USER_WIDTH-1:0]  m_axis_tuser,
  output logic [COUNT_WIDTH-1:0] main_frame_count,
  output logic [COUNT_WIDTH-1:0] inject_frame_count,
  output logic                   busy
);

  typedef enum logic [1:0] {ST_IDLE, ST_MAIN, ST_INJECT} state_t;

  state_t                 state_q, state_d;
  logic                   last_grant_q, last_grant_d;  // 1 = inject was granted last
  logic [COUNT_WIDTH-1:0] main_cnt_q, main_cnt_d, inj_cnt_q, inj_cnt_d;
  logic                   int_ready_q, int_ready_d;
  logic                   out_valid_q, out_valid_d, tmp_valid_q, tmp_valid_d;

  logic [DATA_WIDTH-1:0]  out_data_q, out_data_d, tmp_data_q, tmp_data_d;
  logic [KEEP_WIDTH-1:0]  out_keep_q, out_keep_d, tmp_keep_q, tmp_keep_d;
  logic                   out_last_q, out_last_d, tmp_last_q, tmp_last_d;
  logic [USER_WIDTH-1:0]  out_user_q, out_user_d, tmp_user_q, tmp_user_d;

  logic                   grant_inj, sel_inj, acc;
  logic [DATA_WIDTH-1:0]  in_data;
  logic [KEEP_WIDTH-1:0]  in_keep;
  logic                   in_last;
  logic [USER_WIDTH-1:0]  in_user;

  // Arbitration and source select; readies come straight from the registered int_ready
  always_comb begin
    grant_inj = inj_axis_tvalid &&
                (!s_axis_tvalid || (INJECT_PRIORITY != 0) || !last_grant_q);
    case (state_q)
      ST_MAIN:   sel_inj = 1'b0;
      ST_INJECT: sel_inj = 1'b1;
      default:   sel_inj = grant_inj;
    endcase
    s_axis_tready   = int_ready_q && ((state_q == ST_MAIN) ||
                      ((state_q == ST_IDLE) && s_axis_tvalid && !grant_inj));
    inj_axis_tready = int_ready_q && ((state_q == ST_INJECT) ||
                      ((state_q == ST_IDLE) && grant_inj));
    acc     = sel_inj ? (inj_axis_tvalid && inj_axis_tready)
                      : (s_axis_tvalid && s_axis_tready);
    in_data = sel_inj ? inj_axis_tdata : s_axis_tdata;
    in_keep = sel_inj ? inj_axis_tkeep : s_axis_tkeep;
    in_last = sel_inj ? inj_axis_tlast : s_axis_tlast;
    in_user = sel_inj ? inj_axis_tuser : s_axis_tuser;
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    main_cnt_d   = main_cnt_q;
    inj_cnt_d    = inj_cnt_q;
    if (acc) begin
      if (state_q == ST_IDLE) last_grant_d = sel_inj;
      if (in_last) begin
        state_d = ST_IDLE;
        if (sel_inj) inj_cnt_d = inj_cnt_q + 1'b1;
        else         main_cnt_d = main_cnt_q + 1'b1;
      end else begin
        state_d = sel_inj ? ST_INJECT : ST_MAIN;
      end
    end
  end

  // Skid stage: a beat lands in the output register when it is free, otherwise in temp
  always_comb begin
    int_ready_d = m_axis_tready || (!tmp_valid_q && (!out_valid_q || !acc));
    out_valid_d = out_valid_q;
    tmp_valid_d = tmp_valid_q;
    out_data_d  = out_data_q;
    out_keep_d  = out_keep_q;
    out_last_d  = out_last_q;
    out_user_d  = out_user_q;
    tmp_data_d  = tmp_data_q;
    tmp_keep_d  = tmp_keep_q;
    tmp_last_d  = tmp_last_q;
    tmp_user_d  = tmp_user_q;
    if (int_ready_q) begin
      if (m_axis_tready || !out_valid_q) begin
        out_valid_d = acc;
        out_data_d  = in_data;
        out_keep_d  = in_keep;
        out_last_d  = in_last;
        out_user_d  = in_user;
      end else begin
        tmp_valid_d = acc;
        tmp_data_d  = in_data;
        tmp_keep_d  = in_keep;
        tmp_last_d  = in_last;
        tmp_user_d  = in_user;
      end
    end else if (m_axis_tready) begin
      out_valid_d = tmp_valid_q;
      tmp_valid_d = 1'b0;
      out_data_d  = tmp_data_q;
      out_keep_d  = tmp_keep_q;
      out_last_d  = tmp_last_q;
      out_user_d  = tmp_user_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      last_grant_q <= 1'b1;
      main_cnt_q   <= '0;
      inj_cnt_q    <= '0;
      int_ready_q  <= 1'b0;
      out_valid_q  <= 1'b0;
      tmp_valid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      main_cnt_q   <= main_cnt_d;
      inj_cnt_q    <= inj_cnt_d;
      int_ready_q  <= int_ready_d;
      out_valid_q  <= out_valid_d;
      tmp_valid_q  <= tmp_valid_d;
    end
  end

  always_ff @(posedge clk) begin
    out_data_q <= out_data_d;
    out_keep_q <= out_keep_d;
    out_last_q <= out_last_d;
    out_user_q <= out_user_d;
    tmp_data_q <= tmp_data_d;
    tmp_keep_q <= tmp_keep_d;
    tmp_last_q <= tmp_last_d;
    tmp_user_q <= tmp_user_d;
  end

  assign m_axis_tvalid      = out_valid_q;
  assign m_axis_tdata       = out_data_q;
  assign m_axis_tkeep       = (KEEP_ENABLE != 0) ? out_keep_q : {KEEP_WIDTH{1'b1}};
  assign m_axis_tlast       = out_last_q;
  assign m_axis_tuser       = (USER_ENABLE != 0) ? out_user_q : {USER_WIDTH{1'b0}};
  assign main_frame_count   = main_cnt_q;
  assign inject_frame_count = inj_cnt_q;
  assign busy               = (state_q != ST_IDLE);

endmodule

// File: tb/tb_axis_frame_inject.sv
// Bench for axis_frame_inject: two instances (round-robin with 4-bit counters,
// inject-priority with 16-bit counters), one shared driver and a queue scoreboard.
module tb_axis_frame_inject;

  typedef struct packed {
    logic [15:0] data;
    logic [1:0]  keep;
    logic        last;
    logic        user;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sel = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] s_tdata = '0, inj_tdata = '0;
  logic [1:0]  s_tkeep = '0, inj_tkeep = '0;
  logic        s_tvalid = 1'b0, s_tlast = 1'b0, inj_tvalid = 1'b0, inj_tlast = 1'b0;
  logic [0:0]  s_tuser = '0, inj_tuser = '0;
  logic        m_tready = 1'b0;

  logic        sv_w [2];
  logic        iv_w [2];
  logic        srdy_w [2];
  logic        irdy_w [2];
  logic        mv_w [2];
  logic        ml_w [2];
  logic [0:0]  mu_w [2];
  logic        busy_w [2];
  logic [15:0] md_w [2];
  logic [1:0]  mk_w [2];
  logic [3:0]  mc0, ic0;
  logic [15:0] mc1, ic1;

  assign sv_w[0] = s_tvalid && !sel;
  assign sv_w[1] = s_tvalid && sel;
  assign iv_w[0] = inj_tvalid && !sel;
  assign iv_w[1] = inj_tvalid && sel;

  axis_frame_inject #(.DATA_WIDTH(16), .INJECT_PRIORITY(0), .COUNT_WIDTH(4)) dut0 (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tvalid(sv_w[0]),
    .s_axis_tready(srdy_w[0]), .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser),
    .inj_axis_tdata(inj_tdata), .inj_axis_tkeep(inj_tkeep), .inj_axis_tvalid(iv_w[0]),
    .inj_axis_tready(irdy_w[0]), .inj_axis_tlast(inj_tlast), .inj_axis_tuser(inj_tuser),
    .m_axis_tdata(md_w[0]), .m_axis_tkeep(mk_w[0]), .m_axis_tvalid(mv_w[0]),
    .m_axis_tready(m_tready), .m_axis_tlast(ml_w[0]), .m_axis_tuser(mu_w[0]),
    .main_frame_count(mc0), .inject_frame_count(ic0), .busy(busy_w[0]));

  axis_frame_inject #(.DATA_WIDTH(16), .INJECT_PRIORITY(1), .COUNT_WIDTH(16)) dut1 (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tvalid(sv_w[1]),
    .s_axis_tready(srdy_w[1]), .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser),
    .inj_axis_tdata(inj_tdata), .inj_axis_tkeep(inj_tkeep), .inj_axis_tvalid(iv_w[1]),
    .inj_axis_tready(irdy_w[1]), .inj_axis_tlast(inj_tlast), .inj_axis_tuser(inj_tuser),
    .m_axis_tdata(md_w[1]), .m_axis_tkeep(mk_w[1]), .m_axis_tvalid(mv_w[1]),
    .m_axis_tready(m_tready), .m_axis_tlast(ml_w[1]), .m_axis_tuser(mu_w[1]),
    .main_frame_count(mc1), .inject_frame_count(ic1), .busy(busy_w[1]));

  logic        s_tready, inj_tready, m_tvalid, m_tlast, busy;
  logic [15:0] m_tdata, main_cnt, inj_cnt;
  logic [1:0]  m_tkeep;
  logic [0:0]  m_tuser;
  assign s_tready   = sel ? srdy_w[1] : srdy_w[0];
  assign inj_tready = sel ? irdy_w[1] : irdy_w[0];
  assign m_tvalid   = sel ? mv_w[1] : mv_w[0];
  assign m_tlast    = sel ? ml_w[1] : ml_w[0];
  assign m_tuser    = sel ? mu_w[1] : mu_w[0];
  assign m_tdata    = sel ? md_w[1] : md_w[0];
  assign m_tkeep    = sel ? mk_w[1] : mk_w[0];
  assign busy       = sel ? busy_w[1] : busy_w[0];
  assign main_cnt   = sel ? mc1 : {12'd0, mc0};
  assign inj_cnt    = sel ? ic1 : {12'd0, ic0};

  int n_chk = 0, n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  beat_t main_q[$], inj_q[$], exp_main[$], exp_inj[$];
  bit    seq[$];
  int    fid = 0;
  int    rdy_pct = 100, main_pct = 100, inj_pct = 100;
  bit    started = 0, lat_chk = 0;
  int    main_acc_beats = 0, cyc = 0, first_out = 0, last_out = 0;
  bit    have_first = 0;

  task automatic push_frame(input bit src, input int n);
    beat_t b;
    for (int i = 0; i < n; i++) begin
      b.data = {src, fid[6:0], i[7:0]};
      b.keep = 2'($urandom);
      b.user = 1'($urandom);
      b.last = (i == n - 1);
      if (src) begin inj_q.push_back(b); exp_inj.push_back(b); end
      else begin main_q.push_back(b); exp_main.push_back(b); end
    end
    fid++;
  endtask

  // Driver, model and scoreboard: sample at negedge, drive 1 time unit after posedge
  initial begin : drv
    bit    m_acc, i_acc, any_acc_q, flush, rst_prev, stall_prev, mdl_busy, mdl_src;
    bit    out_in_frame, src;
    int    mdl_main, mdl_inj;
    beat_t prev_out, got, exp;
    logic [31:0] mask;
    any_acc_q = 0; flush = 0; rst_prev = 0; stall_prev = 0; mdl_busy = 0; mdl_src = 0;
    out_in_frame = 0; mdl_main = 0; mdl_inj = 0; prev_out = '0;
    forever begin
      @(negedge clk);
      cyc++;
      mask = sel ? 32'hFFFF : 32'h000F;
      got = {m_tdata, m_tkeep, m_tlast, m_tuser};
      if (started) begin
        check("main_frame_count", main_cnt, mdl_main & mask);
        check("inject_frame_count", inj_cnt, mdl_inj & mask);
        check("busy", busy, mdl_busy);
        if (s_tvalid && inj_tvalid) check("single_grant", s_tready && inj_tready, 0);
        if (mdl_busy && !mdl_src) check("inject_blocked", inj_tready, 0);
        if (mdl_busy && mdl_src) check("main_blocked", s_tready, 0);
        if (lat_chk) check("latency_valid", m_tvalid, any_acc_q);
        if (stall_prev) begin
          check("stall_valid", m_tvalid, 1);
          check("stall_beat", got, prev_out);
        end
      end
      m_acc = s_tvalid && s_tready && !rst;
      i_acc = inj_tvalid && inj_tready && !rst;
      if (m_acc) begin
        main_acc_beats++;
        if (s_tlast) mdl_main++;
        mdl_busy = !s_tlast; mdl_src = 0;
      end
      if (i_acc) begin
        if (inj_tlast) mdl_inj++;
        mdl_busy = !inj_tlast; mdl_src = 1;
      end
      any_acc_q = m_acc || i_acc;
      if (m_tvalid && m_tready && !rst) begin
        src = m_tdata[15];
        if (out_in_frame) check("frame_unbroken", src, mdl_src_out(src, out_in_frame, seq));
        else seq.push_back(src);
        if (src ? (exp_inj.size() == 0) : (exp_main.size() == 0)) check("extra_beat", 1, 0);
        else begin
          exp = src ? exp_inj.pop_front() : exp_main.pop_front();
          check("beat", got, exp);
        end
        out_in_frame = !m_tlast;
        if (!have_first) begin first_out = cyc; have_first = 1; end
        last_out = cyc;
      end
      stall_prev = m_tvalid && !m_tready && !rst;
      prev_out = got;
      if (rst) begin
        mdl_main = 0; mdl_inj = 0; mdl_busy = 0;
        if (!rst_prev) begin
          exp_main.delete(); exp_inj.delete(); seq.delete();
          out_in_frame = 0; flush = 1;
        end
      end
      rst_prev = rst;

      @(posedge clk);
      #1;
      if (flush) begin
        main_q.delete(); inj_q.delete();
        s_tvalid = 0; inj_tvalid = 0; flush = 0;
      end else begin
        if (m_acc) void'(main_q.pop_front());
        if (i_acc) void'(inj_q.pop_front());
        if (!s_tvalid || m_acc) begin
          s_tvalid = (main_q.size() > 0) && ($urandom_range(0, 99) < main_pct);
          if (s_tvalid) {s_tdata, s_tkeep, s_tlast, s_tuser} = main_q[0];
        end
        if (!inj_tvalid || i_acc) begin
          inj_tvalid = (inj_q.size() > 0) && ($urandom_range(0, 99) < inj_pct);
          if (inj_tvalid) {inj_tdata, inj_tkeep, inj_tlast, inj_tuser} = inj_q[0];
        end
      end
      m_tready = ($urandom_range(0, 99) < rdy_pct);
    end
  end

  // Source of the frame currently open on the output (last entry pushed at frame start)
  function automatic bit mdl_src_out(input bit cur, input bit in_frame, input bit q[$]);
    if (!in_frame || q.size() == 0) return cur;
    return q[q.size() - 1];
  endfunction

  task automatic do_reset(input bit new_sel);
    @(posedge clk); #2;
    rst = 1; lat_chk = 0;
    repeat (2) @(posedge clk);
    #2;
    sel = new_sel; rst = 0; have_first = 0;
  endtask

  task automatic wait_drain(input int budget);
    int c = 0;
    while ((main_q.size() != 0 || inj_q.size() != 0 || exp_main.size() != 0 ||
            exp_inj.size() != 0 || s_tvalid || inj_tvalid || m_tvalid) && c < budget) begin
      @(posedge clk); #2; c++;
    end
    check("drain_in_time", (c < budget), 1);
    repeat (2) @(posedge clk);
    #2;
  endtask

  task automatic wait_main_beats(input int target);
    int c = 0;
    while (main_acc_beats < target && c < 200) begin @(posedge clk); #2; c++; end
    check("main_beats_reached", (main_acc_beats >= target), 1);
  endtask

  initial begin : main_seq
    int base;
    repeat (3) @(posedge clk);
    #2;
    rst = 0; started = 1;
    @(negedge clk);
    check("reset_m_tvalid", m_tvalid, 0);
    check("reset_busy", busy, 0);
    check("reset_main_count", main_cnt, 0);
    check("reset_inject_count", inj_cnt, 0);

    // Main only, straight through
    do_reset(0); rdy_pct = 100; lat_chk = 1;
    push_frame(0, 4); push_frame(0, 1); push_frame(0, 7);
    wait_drain(200);
    check("t1_main_count", main_cnt, 3);
    check("t1_inject_count", inj_cnt, 0);
    check("t1_frames", seq.size(), 3);
    check("t1_span", last_out - first_out + 1, 12);

    // Round-robin contention, main wins the first tie after reset
    do_reset(0); lat_chk = 1;
    for (int i = 0; i < 5; i++) begin push_frame(0, 2); push_frame(1, 2); end
    wait_drain(200);
    check("t2_frames", seq.size(), 10);
    for (int i = 0; i < seq.size(); i++) check("t2_alternate", seq[i], i % 2);
    check("t2_span", last_out - first_out + 1, 20);
    check("t2_counts_equal", main_cnt, inj_cnt);
    check("t2_main_count", main_cnt, 5);

    // Inject priority
    do_reset(1); lat_chk = 1;
    for (int i = 0; i < 3; i++) begin push_frame(0, 2); push_frame(1, 3); end
    wait_drain(200);
    check("t3_frames", seq.size(), 6);
    for (int i = 0; i < seq.size(); i++) check("t3_inject_first", seq[i], (i < 3) ? 1 : 0);
    seq.delete();
    base = main_acc_beats;
    push_frame(0, 6);
    wait_main_beats(base + 2);
    push_frame(1, 1);
    wait_drain(200);
    check("t3b_frames", seq.size(), 2);
    if (seq.size() == 2) begin
      check("t3b_main_finishes", seq[0], 0);
      check("t3b_inject_after", seq[1], 1);
    end
    check("t3b_inject_count", inj_cnt, 4);

    // Backpressure with random source gaps
    do_reset(0); rdy_pct = 50; main_pct = 70; inj_pct = 70;
    for (int i = 0; i < 4; i++) begin push_frame(0, 16); push_frame(1, 16); end
    wait_drain(5000);
    check("t4_frames", seq.size(), 8);
    check("t4_main_count", main_cnt, 4);
    check("t4_inject_count", inj_cnt, 4);
    rdy_pct = 100; main_pct = 100; inj_pct = 100;

    // Counter wrap on the 4-bit instance
    do_reset(0); lat_chk = 1;
    for (int i = 0; i < 17; i++) push_frame(1, 1);
    wait_drain(300);
    check("t5_inject_wrap", inj_cnt, 1);
    check("t5_main_count", main_cnt, 0);

    // Reset on beat 3 of a 6-beat frame
    do_reset(0);
    base = main_acc_beats;
    push_frame(0, 6);
    wait_main_beats(base + 3);
    rst = 1;
    @(posedge clk); #2;
    push_frame(0, 3);
    @(negedge clk);
    check("t6_m_tvalid", m_tvalid, 0);
    check("t6_busy", busy, 0);
    check("t6_main_count", main_cnt, 0);
    @(posedge clk); #2;
    rst = 0;
    @(negedge clk);
    check("t6_valid_offered", s_tvalid, 1);
    check("t6_ready_held_low", s_tready, 0);
    @(negedge clk);
    check("t6_ready_follows", s_tready, 1);
    wait_drain(200);
    check("t6_frames", seq.size(), 1);
    check("t6_main_count_after", main_cnt, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin : watchdog
    #(1_000_000);
    $display("FAIL global_timeout: simulation did not finish, got %0d checks, expected completion", n_chk);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/axis_frame_inject.md
# axis_frame_inject

AXI4-Stream frame injector: passes a main stream through to a single output and inserts whole frames from a second inject stream between main frames, never splitting a frame from either source. It is the insertion counterpart of the stream tap: the tap copies frames out of a live stream, this block adds frames into one. Typical use is inserting locally generated control or keepalive packets into the packet datapath. A registered two-entry skid output stage isolates the downstream ready from both upstream ready paths.

## Interface
- DATA_WIDTH, 8, tdata width in bits
- KEEP_ENABLE, (DATA_WIDTH>8), propagate tkeep; when 0, m_axis_tkeep is driven all ones
- KEEP_WIDTH, ((DATA_WIDTH+7)/8), tkeep width
- USER_ENABLE, 1, propagate tuser; when 0, m_axis_tuser is driven zero
- USER_WIDTH, 1, tuser width
- INJECT_PRIORITY, 0, 0 = round-robin between sources at frame boundaries; 1 = inject wins whenever both are valid
- COUNT_WIDTH, 16, width of the frame counters

Ports:
- clk  in  1  clock; all logic on the rising edge
- rst  in  1  reset, synchronous, active-high
- s_axis_tdata/tkeep/tvalid/tready/tlast/tuser  in (tready out)  per params  main input stream
- inj_axis_tdata/tkeep/tvalid/tready/tlast/tuser  in (tready out)  per params  inject input stream
- m_axis_tdata/tkeep/tvalid/tready/tlast/tuser  out (tready in)  per params  merged output stream
- main_frame_count  out  COUNT_WIDTH  main frames forwarded (count of accepted tlast beats)
- inject_frame_count  out  COUNT_WIDTH  inject frames forwarded
- busy  out  1  high while a frame is in progress (state not IDLE)

## Operation
- States: IDLE, MAIN, INJECT.
- IDLE: a grant is computed combinationally from s_axis_tvalid and inj_axis_tvalid.
  - Only one source valid: that source is granted.
  - Both valid, INJECT_PRIORITY=1: inject is granted.
  - Both valid, INJECT_PRIORITY=0: the source opposite last_grant_reg is granted.
  - The granted source's tready = int_ready_reg in that same cycle.
  - On an accepted beat: last_grant_reg updates to the granted source. tlast=1 stays in IDLE (single-beat frame); tlast=0 moves to MAIN or INJECT.
- MAIN / INJECT: only the owning source sees tready = int_ready_reg; the other source's tready = 0. Accepted beat with tlast=1 returns to IDLE.
- Beat fields (data, keep, last, user) are copied unmodified; no frame is truncated, dropped or altered.
- Counters increment by 1 on each accepted tlast beat of the respective source and wrap from 2^COUNT_WIDTH-1 to 0.
- Output stage: main and temp registers (skid).
  - int_ready_reg is the registered value of m_axis_tready OR (temp empty AND (output empty OR no beat this cycle)).
  - A beat goes to the output register if it is empty or being consumed, otherwise to temp.
  - Temp drains to output when m_axis_tready is high and no new beat is written.
- Reset values: m_axis_tvalid=0, s_axis_tready=0, inj_axis_tready=0, state=IDLE, last_grant_reg=inject (so main wins the first tie), both counters 0, busy=0. Data registers are don't-care.

## Timing
- Latency: a beat accepted at edge N appears on m_axis with tvalid=1 after edge N; latency is 1 cycle.
- After rst deasserts, input readies stay 0 for one cycle, then follow int_ready_reg.
- With m_axis_tready held 1, throughput is 1 beat/cycle with zero idle cycles at frame boundaries, including an immediate switch between sources.
- Back-to-back frames: a frame's tlast beat and the next frame's first beat (from either source) may be accepted on consecutive cycles.
- m_axis_tready deasserted: at most 2 beats are absorbed (output + temp) before input readies drop. No beat is lost or duplicated, and m_axis data/tvalid hold stable while tvalid=1 and tready=0.
- Simultaneous events: a tlast accept and a counter wrap in the same cycle are both honoured. Both sources valid in IDLE produce exactly one grant; the loser's tready stays 0 until the next IDLE decision.
- Reset mid-frame: state returns to IDLE and m_axis_tvalid=0 on the next cycle. Partial frames are discarded without tlast; upstream and downstream share the same reset.

## Test plan
- Main only: 3 frames of 4, 1 and 7 beats, m_axis_tready=1 -> output identical in order with 1-cycle latency; main_frame_count=3, inject_frame_count=0.
- Contention, INJECT_PRIORITY=0: both sources continuously valid with 2-beat frames -> output alternates main, inject, main, inject with no gaps; counters equal after 10 frames.
- Contention, INJECT_PRIORITY=1: both sources valid -> all inject frames precede any main frame; an inject arriving mid main frame waits for main tlast.
- Backpressure: random 50% m_axis_tready with 16-beat frames from both sources -> scoreboard shows every beat exactly once, frames unbroken, tvalid/data stable while stalled.
- Counter wrap with COUNT_WIDTH=4: 17 single-beat inject frames -> inject_frame_count reads 1.
- Reset on beat 3 of a 6-beat main frame -> m_axis_tvalid=0 next cycle, counters 0, readies 0 for one cycle; a following frame passes intact.
